// File: rtl/chip8_pkg.sv
// Shared definitions for the CHIP-8 memory subsystem: boot states, default
// base addresses and the built-in hexadecimal glyph table.
package chip8_pkg;

    typedef enum logic [1:0] {
        ST_CLEAR,
        ST_FONT,
        ST_LOAD,
        ST_RUN
    } boot_state_t;

    localparam logic [11:0] FONT_BASE_DEFAULT = 12'h050;
    localparam logic [11:0] PROG_BASE_DEFAULT = 12'h200;
    localparam int          FONT_BYTES        = 80;

    // Glyphs 0-F, five rows each; index 0 is the top row of glyph 0.
    localparam logic [0:79][7:0] FONTSET = {
        8'hF0, 8'h90, 8'h90, 8'h90, 8'hF0,
        8'h20, 8'h60, 8'h20, 8'h20, 8'h70,
        8'hF0, 8'h10, 8'hF0, 8'h80, 8'hF0,
        8'hF0, 8'h10, 8'hF0, 8'h10, 8'hF0,
        8'h90, 8'h90, 8'hF0, 8'h10, 8'h10,
        8'hF0, 8'h80, 8'hF0, 8'h10, 8'hF0,
        8'hF0, 8'h80, 8'hF0, 8'h90, 8'hF0,
        8'hF0, 8'h10, 8'h20, 8'h40, 8'h40,
        8'hF0, 8'h90, 8'hF0, 8'h90, 8'hF0,
        8'hF0, 8'h90, 8'hF0, 8'h10, 8'hF0,
        8'hF0, 8'h90, 8'hF0, 8'h90, 8'h90,
        8'hE0, 8'h90, 8'hE0, 8'h90, 8'hE0,
        8'hF0, 8'h80, 8'h80, 8'h80, 8'hF0,
        8'hE0, 8'h90, 8'h90, 8'h90, 8'hE0,
        8'hF0, 8'h80, 8'hF0, 8'h80, 8'hF0,
        8'hF0, 8'h80, 8'hF0, 8'h80, 8'h80
    };

endpackage

// File: rtl/chip8_memory_ram.sv
// Byte-wide RAM with one synchronous write port and one asynchronous read
// port; a same-cycle read of the written address returns the old byte.
module chip8_ram #(
    parameter int MEM_DEPTH = 4096
) (
    input  logic        clk,
    input  logic        we,
    input  logic [11:0] waddr,
    input  logic [7:0]  wdata,
    input  logic [11:0] raddr,
    output logic [7:0]  rdata
);

    logic [7:0] mem [0:MEM_DEPTH-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/chip8_memory.sv
// CHIP-8 main memory: boot sequencer (clear, font, program load) in front of
// a 4 KiB RAM that the CPU then reads asynchronously and writes synchronously.
module chip8_memory
    import chip8_pkg::*;
#(
    parameter int          MEM_DEPTH      = 4096,
    parameter logic [11:0] FONT_BASE      = FONT_BASE_DEFAULT,
    parameter logic [11:0] PROG_BASE      = PROG_BASE_DEFAULT,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        load_valid,
    input  logic [7:0]  load_data,
    input  logic        load_last,
    output logic        load_ready,
    input  logic [11:0] rd_memory_address,
    output logic [7:0]  rd_memory_data,
    input  logic [11:0] wr_memory_address,
    input  logic [7:0]  wr_memory_data,
    input  logic        wr_go,
    output logic        mem_ready,
    output logic [11:0] load_count,
    output logic        load_overflow
);

    localparam logic [11:0] LAST_ADDR = 12'(MEM_DEPTH - 1);
    localparam logic [11:0] FONT_LAST = 12'(FONT_BYTES - 1);

    boot_state_t state;
    logic [11:0] ptr;

    logic        ram_we;
    logic [11:0] ram_addr;
    logic [7:0]  ram_data;

    assign load_ready = (state == ST_LOAD);
    assign mem_ready  = (state == ST_RUN);

    // The states own the single write port in turn, so a plain mux suffices.
    // Reset suppresses every write, so a byte offered during reset is dropped.
    always_comb begin
        ram_we   = 1'b0;
        ram_addr = ptr;
        ram_data = 8'h00;
        unique case (state)
            ST_CLEAR: begin
                ram_we = !rst_in;
            end
            ST_FONT: begin
                ram_we   = !rst_in;
                ram_addr = FONT_BASE + ptr;
                ram_data = FONTSET[ptr[6:0]];
            end
            ST_LOAD: begin
                ram_we   = load_valid && !rst_in;
                ram_data = load_data;
            end
            ST_RUN: begin
                ram_we   = wr_go && !rst_in;
                ram_addr = wr_memory_address;
                ram_data = wr_memory_data;
            end
            default: begin
                ram_we = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            if (CLEAR_ON_RESET) begin
                state <= ST_CLEAR;
            end else begin
                state <= ST_FONT;
            end
            ptr           <= 12'h000;
            load_count    <= 12'h000;
            load_overflow <= 1'b0;
        end else begin
            unique case (state)
                ST_CLEAR: begin
                    if (ptr == LAST_ADDR) begin
                        ptr   <= 12'h000;
                        state <= ST_FONT;
                    end else begin
                        ptr <= ptr + 12'd1;
                    end
                end
                ST_FONT: begin
                    if (ptr == FONT_LAST) begin
                        ptr   <= PROG_BASE;
                        state <= ST_LOAD;
                    end else begin
                        ptr <= ptr + 12'd1;
                    end
                end
                ST_LOAD: begin
                    if (load_valid) begin
                        load_count <= load_count + 12'd1;
                        // The pointer parks at the top of RAM rather than wrapping onto the font.
                        if (ptr != 12'hFFF) begin
                            ptr <= ptr + 12'd1;
                        end
                        if (load_last) begin
                            state <= ST_RUN;
                        end else if (ptr == 12'hFFF) begin
                            load_overflow <= 1'b1;
                            state         <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    state <= ST_RUN;
                end
                default: begin
                    state <= ST_RUN;
                end
            endcase
        end
    end

    chip8_ram #(
        .MEM_DEPTH(MEM_DEPTH)
    ) u_ram (
        .clk  (clk_in),
        .we   (ram_we),
        .waddr(ram_addr),
        .wdata(ram_data),
        .raddr(rd_memory_address),
        .rdata(rd_memory_data)
    );

endmodule

// File: tb/tb_chip8_memory.sv
// Directed bench for chip8_memory: boot timing, font/image contents, CPU port
// timing, write gating, backpressure, overflow and reset during load.
module tb_chip8_memory;

    logic        clk_in;
    logic        rst_in;
    logic        load_valid;
    logic [7:0]  load_data;
    logic        load_last;
    logic        load_ready;
    logic [11:0] rd_memory_address;
    logic [7:0]  rd_memory_data;
    logic [11:0] wr_memory_address;
    logic [7:0]  wr_memory_data;
    logic        wr_go;
    logic        mem_ready;
    logic [11:0] load_count;
    logic        load_overflow;

    int n_checks = 0;
    int n_fail   = 0;

    chip8_memory dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .load_valid       (load_valid),
        .load_data        (load_data),
        .load_last        (load_last),
        .load_ready       (load_ready),
        .rd_memory_address(rd_memory_address),
        .rd_memory_data   (rd_memory_data),
        .wr_memory_address(wr_memory_address),
        .wr_memory_data   (wr_memory_data),
        .wr_go            (wr_go),
        .mem_ready        (mem_ready),
        .load_count       (load_count),
        .load_overflow    (load_overflow)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // Read through the CPU port, sampled on the falling edge.
    task automatic peek(input string tag, input logic [11:0] addr, input logic [7:0] exp);
        rd_memory_address = addr;
        @(negedge clk_in);
        check(tag, {24'h0, rd_memory_data}, {24'h0, exp});
    endtask

    task automatic pulse_reset();
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
    endtask

    // Counts edges until load_ready rises, bounded.
    task automatic wait_load(output int cycles);
        cycles = 0;
        while (!load_ready && cycles < 6000) begin
            tick();
            cycles++;
        end
    endtask

    logic [7:0] img [0:3];
    int         cyc;
    int         k;
    logic       acc;

    initial begin
        img[0] = 8'hA2; img[1] = 8'h2A; img[2] = 8'h60; img[3] = 8'h0C;
        rst_in = 1'b1;
        load_valid = 1'b0;
        load_data = 8'h00;
        load_last = 1'b0;
        rd_memory_address = 12'h000;
        wr_memory_address = 12'h000;
        wr_memory_data = 8'h00;
        wr_go = 1'b0;
        tick();
        tick();
        check("rst_mem_ready", {31'h0, mem_ready}, 32'h0);
        check("rst_load_ready", {31'h0, load_ready}, 32'h0);
        check("rst_load_count", {20'h0, load_count}, 32'h0);
        check("rst_overflow", {31'h0, load_overflow}, 32'h0);
        rst_in = 1'b0;

        // Boot with continuous load_valid and a 4-byte image.
        load_valid = 1'b1;
        cyc = 0;
        k = 0;
        while (!mem_ready && cyc < 6000) begin
            load_data = img[k & 3];
            load_last = (k == 3);
            acc = load_ready;
            tick();
            cyc++;
            if (acc) k++;
        end
        load_valid = 1'b0;
        load_last = 1'b0;
        check("boot_cycles", cyc, 32'd4180);
        check("boot_mem_ready", {31'h0, mem_ready}, 32'h1);
        check("boot_load_count", {20'h0, load_count}, 32'd4);
        check("boot_overflow", {31'h0, load_overflow}, 32'h0);
        check("run_load_ready", {31'h0, load_ready}, 32'h0);
        peek("font_first", 12'h050, 8'hF0);
        peek("font_glyph1", 12'h055, 8'h20);
        peek("font_last", 12'h09F, 8'h80);
        peek("img0", 12'h200, 8'hA2);
        peek("img1", 12'h201, 8'h2A);
        peek("img2", 12'h202, 8'h60);
        peek("img3", 12'h203, 8'h0C);
        peek("cleared_0", 12'h000, 8'h00);
        peek("cleared_fff", 12'hFFF, 8'h00);

        // Asynchronous read: address applied after an edge, data before the next.
        tick();
        rd_memory_address = 12'h201;
        #1;
        check("async_read", {24'h0, rd_memory_data}, 32'h2A);

        // Write/read collision on 0x300.
        tick();
        wr_go = 1'b1;
        wr_memory_address = 12'h300;
        wr_memory_data = 8'h5A;
        rd_memory_address = 12'h300;
        #1;
        check("collide_old", {24'h0, rd_memory_data}, 32'h00);
        tick();
        wr_go = 1'b0;
        #1;
        check("collide_new", {24'h0, rd_memory_data}, 32'h5A);

        // Font area is writable once running.
        wr_go = 1'b1;
        wr_memory_address = 12'h050;
        wr_memory_data = 8'h11;
        tick();
        wr_go = 1'b0;
        peek("run_font_write", 12'h050, 8'h11);

        // Reboot, load two bytes, then check CPU writes are ignored in ST_LOAD.
        pulse_reset();
        check("reboot_mem_ready", {31'h0, mem_ready}, 32'h0);
        wait_load(cyc);
        check("reboot_to_load", cyc, 32'd4176);
        load_valid = 1'b1;
        load_data = 8'h77;
        tick();
        load_data = 8'h88;
        tick();
        load_valid = 1'b0;
        check("partial_count", {20'h0, load_count}, 32'd2);
        wr_go = 1'b1;
        wr_memory_address = 12'h200;
        wr_memory_data = 8'hEE;
        tick();
        wr_go = 1'b0;
        peek("gated_write", 12'h200, 8'h77);
        peek("font_restored", 12'h050, 8'hF0);

        // Reset with a byte on offer: reset wins, nothing accepted during boot.
        load_valid = 1'b1;
        load_data = 8'h99;
        pulse_reset();
        check("midload_count", {20'h0, load_count}, 32'd0);
        check("midload_mem_ready", {31'h0, mem_ready}, 32'h0);
        check("midload_load_ready", {31'h0, load_ready}, 32'h0);
        wait_load(cyc);
        check("midload_to_load", cyc, 32'd4176);
        check("midload_count_boot", {20'h0, load_count}, 32'd0);
        check("midload_not_ready", {31'h0, mem_ready}, 32'h0);

        // Reload with random load_valid; only handshakes advance the count.
        cyc = 0;
        k = 0;
        while (!mem_ready && cyc < 500) begin
            load_valid = 1'($urandom_range(0, 1));
            load_data = 8'h30 + 8'(k);
            load_last = (k == 9);
            acc = load_valid && load_ready;
            tick();
            cyc++;
            if (acc) k++;
            check("bp_count", {20'h0, load_count}, k);
        end
        load_valid = 1'b0;
        load_last = 1'b0;
        check("bp_done", {31'h0, mem_ready}, 32'h1);
        check("bp_final_count", {20'h0, load_count}, 32'd10);
        peek("bp_byte0", 12'h200, 8'h30);
        peek("bp_byte9", 12'h209, 8'h39);

        // Full-length image with no last byte.
        pulse_reset();
        wait_load(cyc);
        check("ovf_to_load", cyc, 32'd4176);
        load_valid = 1'b1;
        load_last = 1'b0;
        for (int i = 0; i < 3584; i++) begin
            load_data = 8'(i) ^ 8'h5A;
            tick();
        end
        check("ovf_flag", {31'h0, load_overflow}, 32'h1);
        check("ovf_mem_ready", {31'h0, mem_ready}, 32'h1);
        check("ovf_count", {20'h0, load_count}, 32'd3584);
        load_data = 8'h33;
        tick();
        load_valid = 1'b0;
        check("ovf_count_hold", {20'h0, load_count}, 32'd3584);
        peek("ovf_top", 12'hFFF, 8'hA5);
        peek("ovf_first", 12'h200, 8'h5A);
        peek("ovf_no_wrap", 12'h000, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
